// File: rtl/branch_resolve_ctrl_if.sv
// Bus between ID / forwarding / PC-select and the branch resolve controller.
// The master side drives the branch request and operands; the slave side
// (the controller) returns the stall, the redirect and the statistics.
interface branch_resolve_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              br_valid;
  logic              br_beq;
  logic              br_bne;
  logic              br_blez;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic              ops_ready;
  logic [ADDR_W-1:0] br_target;
  logic              clr_cnt;
  logic              stall_id;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush_if;
  logic [CNT_W-1:0]  cnt_taken;
  logic [CNT_W-1:0]  cnt_not_taken;
  logic              err_timeout;

  modport master (
    output br_valid, br_beq, br_bne, br_blez, op_a, op_b, ops_ready,
           br_target, clr_cnt,
    input  stall_id, redirect_valid, redirect_pc, flush_if,
           cnt_taken, cnt_not_taken, err_timeout
  );

  modport slave (
    input  br_valid, br_beq, br_bne, br_blez, op_a, op_b, ops_ready,
           br_target, clr_cnt,
    output stall_id, redirect_valid, redirect_pc, flush_if,
           cnt_taken, cnt_not_taken, err_timeout
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Conditional-branch resolution sequencer for the 5-stage core.
// Accepts beq/bne/blez from ID, stalls until forwarded operands are ready,
// issues a one-cycle PC redirect + IF flush on taken, and keeps saturating
// taken/not-taken counters plus a sticky operand-wait timeout flag.
module branch_resolve_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_OPS, S_REDIRECT} state_t;
  typedef enum logic [1:0] {T_BEQ, T_BNE, T_BLEZ}           br_type_t;

  // Wait counter must be able to hold MAX_WAIT+1.
  localparam int               WAIT_W   = $clog2(MAX_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_HI  = WAIT_W'(MAX_WAIT);

  state_t            r_state;
  br_type_t          r_type;
  logic [ADDR_W-1:0] r_target;
  logic [WAIT_W-1:0] r_wait;
  logic              r_stall;
  logic              r_redir;
  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_cnt_t;
  logic [CNT_W-1:0]  r_cnt_nt;
  logic              r_err;

  logic     w_type_valid;
  logic     w_accept;
  logic     w_resolve;
  logic     w_taken;
  logic     w_nt_inc;
  logic     w_timeout;
  br_type_t w_new_type;
  br_type_t w_eval_type;

  assign w_type_valid = bus.br_beq | bus.br_bne | bus.br_blez;
  // Priority beq > bne > blez when several type bits are set.
  assign w_new_type   = bus.br_beq ? T_BEQ : (bus.br_bne ? T_BNE : T_BLEZ);
  // In IDLE the live type is evaluated; while waiting the captured copy is.
  assign w_eval_type  = (r_state == S_IDLE) ? w_new_type : r_type;
  assign w_accept     = (r_state == S_IDLE) & bus.br_valid & w_type_valid;
  assign w_resolve    = bus.ops_ready & (w_accept | (r_state == S_WAIT_OPS));
  assign w_nt_inc     = w_resolve & ~w_taken;
  // The edge that brings the wait counter to MAX_WAIT+1 raises the error.
  assign w_timeout    = (r_state == S_WAIT_OPS) & ~bus.ops_ready & (r_wait >= WAIT_HI);

  // Branch condition on the live forwarded operands.
  always_comb begin
    w_taken = 1'b0;
    case (w_eval_type)
      T_BEQ:   w_taken = (bus.op_a == bus.op_b);
      T_BNE:   w_taken = (bus.op_a != bus.op_b);
      default: w_taken = bus.op_a[31] | (bus.op_a == 32'd0);
    endcase
  end

  // Resolve FSM; stall/redirect/pc are registered alongside the state so
  // they always match the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_type   <= T_BEQ;
      r_target <= '0;
      r_wait   <= '0;
      r_stall  <= 1'b0;
      r_redir  <= 1'b0;
      r_pc     <= '0;
    end else begin
      r_stall <= 1'b0;
      r_redir <= 1'b0;
      r_pc    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_type   <= w_new_type;
            r_target <= bus.br_target;
            if (bus.ops_ready) begin
              if (w_taken) begin
                r_state <= S_REDIRECT;
                r_redir <= 1'b1;
                r_pc    <= bus.br_target;
              end
            end else begin
              r_state <= S_WAIT_OPS;
              r_wait  <= WAIT_W'(1);
              r_stall <= 1'b1;
            end
          end
        end
        S_WAIT_OPS: begin
          if (bus.ops_ready) begin
            r_wait <= '0;
            if (w_taken) begin
              r_state <= S_REDIRECT;
              r_redir <= 1'b1;
              r_pc    <= r_target;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_stall <= 1'b1;
            if (r_wait != WAIT_SAT) r_wait <= r_wait + WAIT_W'(1);
          end
        end
        // One-cycle redirect; anything in ID now is wrong-path.
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating statistics and sticky timeout; clear beats any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_t  <= '0;
      r_cnt_nt <= '0;
      r_err    <= 1'b0;
    end else if (bus.clr_cnt) begin
      r_cnt_t  <= '0;
      r_cnt_nt <= '0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == S_REDIRECT) && (r_cnt_t != '1)) r_cnt_t <= r_cnt_t + CNT_W'(1);
      if (w_nt_inc && (r_cnt_nt != '1))               r_cnt_nt <= r_cnt_nt + CNT_W'(1);
      if (w_timeout)                                  r_err <= 1'b1;
    end
  end

  assign bus.stall_id       = r_stall;
  assign bus.redirect_valid = r_redir;
  assign bus.flush_if       = r_redir;
  assign bus.redirect_pc    = r_pc;
  assign bus.cnt_taken      = r_cnt_t;
  assign bus.cnt_not_taken  = r_cnt_nt;
  assign bus.err_timeout    = r_err;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl. Counters are built 8 bits wide so
// saturation is reachable in a few hundred cycles.
module tb_branch_resolve_ctrl;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_resolve_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_WAIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic beq, input logic bne, input logic blez,
                       input logic [31:0] a, input logic [31:0] b, input logic rdy,
                       input logic [31:0] tgt);
    bus.br_valid  = v;
    bus.br_beq    = beq;
    bus.br_bne    = bne;
    bus.br_blez   = blez;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.ops_ready = rdy;
    bus.br_target = tgt;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.clr_cnt = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", bus.stall_id); end
    checks++; if (bus.redirect_valid !== 1'b0 || bus.flush_if !== 1'b0) begin errors++; $display("FAIL rst_redir got %0b/%0b want 0/0", bus.redirect_valid, bus.flush_if); end
    checks++; if (bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %0h want 0", bus.redirect_pc); end
    checks++; if (bus.cnt_taken !== 8'h0 || bus.cnt_not_taken !== 8'h0) begin errors++; $display("FAIL rst_cnt got %0h/%0h want 0/0", bus.cnt_taken, bus.cnt_not_taken); end
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", bus.err_timeout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_beq_taken;
    drive(1, 1, 0, 0, 32'h1234, 32'h1234, 1, 32'h400);
    step;
    checks++; if (bus.redirect_valid !== 1'b1 || bus.flush_if !== 1'b1) begin errors++; $display("FAIL beq_redir got %0b/%0b want 1/1", bus.redirect_valid, bus.flush_if); end
    checks++; if (bus.redirect_pc !== 32'h400) begin errors++; $display("FAIL beq_pc got %0h want 400", bus.redirect_pc); end
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL beq_stall got %0b want 0", bus.stall_id); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    checks++; if (bus.redirect_valid !== 1'b0 || bus.flush_if !== 1'b0 || bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL beq_one_cycle got %0b/%0b/%0h want 0/0/0", bus.redirect_valid, bus.flush_if, bus.redirect_pc); end
    checks++; if (bus.cnt_taken !== 8'd1) begin errors++; $display("FAIL beq_cnt got %0d want 1", bus.cnt_taken); end
  endtask

  task automatic test_conditions;
    // bne equal -> not taken
    drive(1, 0, 1, 0, 5, 5, 1, 32'h500);
    step;
    checks++; if (bus.redirect_valid !== 1'b0 || bus.stall_id !== 1'b0) begin errors++; $display("FAIL bne_nt got %0b/%0b want 0/0", bus.redirect_valid, bus.stall_id); end
    checks++; if (bus.cnt_not_taken !== 8'd1) begin errors++; $display("FAIL bne_cnt got %0d want 1", bus.cnt_not_taken); end
    // blez negative -> taken
    drive(1, 0, 0, 1, 32'hFFFF_FFFF, 0, 1, 32'h600);
    step;
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h600) begin errors++; $display("FAIL blez_neg got %0b/%0h want 1/600", bus.redirect_valid, bus.redirect_pc); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    checks++; if (bus.cnt_taken !== 8'd2) begin errors++; $display("FAIL blez_neg_cnt got %0d want 2", bus.cnt_taken); end
    // blez positive -> not taken
    drive(1, 0, 0, 1, 1, 0, 1, 32'h700);
    step;
    checks++; if (bus.redirect_valid !== 1'b0 || bus.cnt_not_taken !== 8'd2) begin errors++; $display("FAIL blez_pos got %0b/%0d want 0/2", bus.redirect_valid, bus.cnt_not_taken); end
    // blez zero -> taken
    drive(1, 0, 0, 1, 0, 32'h55, 1, 32'h740);
    step;
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h740) begin errors++; $display("FAIL blez_zero got %0b/%0h want 1/740", bus.redirect_valid, bus.redirect_pc); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    // all type bits, equal positive operands: beq wins -> taken
    drive(1, 1, 1, 1, 9, 9, 1, 32'h780);
    step;
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h780) begin errors++; $display("FAIL prio_beq got %0b/%0h want 1/780", bus.redirect_valid, bus.redirect_pc); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    checks++; if (bus.cnt_taken !== 8'd4) begin errors++; $display("FAIL prio_cnt got %0d want 4", bus.cnt_taken); end
    // bne+blez, operands 0/0: bne wins -> not taken
    drive(1, 0, 1, 1, 0, 0, 1, 32'h7C0);
    step;
    checks++; if (bus.redirect_valid !== 1'b0 || bus.cnt_not_taken !== 8'd3) begin errors++; $display("FAIL prio_bne got %0b/%0d want 0/3", bus.redirect_valid, bus.cnt_not_taken); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step;
  endtask

  task automatic test_wait_ops;
    drive(1, 1, 0, 0, 1, 2, 0, 32'h800);
    step;
    checks++; if (bus.stall_id !== 1'b1 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL wait_c1 got %0b/%0b want 1/0", bus.stall_id, bus.redirect_valid); end
    drive(0, 0, 0, 0, 1, 2, 0, 32'hDEAD);
    step;
    checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL wait_c2 got %0b want 1", bus.stall_id); end
    step;
    checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL wait_c3 got %0b want 1", bus.stall_id); end
    // live bne request is ignored: captured beq with equal operands -> taken
    drive(1, 0, 1, 0, 7, 7, 1, 32'hBEEF);
    step;
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h800 || bus.stall_id !== 1'b0) begin errors++; $display("FAIL wait_redir got %0b/%0h/%0b want 1/800/0", bus.redirect_valid, bus.redirect_pc, bus.stall_id); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    checks++; if (bus.cnt_taken !== 8'd5 || bus.cnt_not_taken !== 8'd3) begin errors++; $display("FAIL wait_cnt got %0d/%0d want 5/3", bus.cnt_taken, bus.cnt_not_taken); end
  endtask

  task automatic test_timeout;
    drive(1, 1, 0, 0, 1, 2, 0, 32'h900);
    step;
    drive(0, 0, 0, 0, 1, 2, 0, 32'h0);
    for (int i = 2; i <= 8; i++) step;
    checks++; if (bus.err_timeout !== 1'b0 || bus.stall_id !== 1'b1) begin errors++; $display("FAIL tmo_before got %0b/%0b want 0/1", bus.err_timeout, bus.stall_id); end
    step;
    checks++; if (bus.err_timeout !== 1'b1 || bus.stall_id !== 1'b1) begin errors++; $display("FAIL tmo_set got %0b/%0b want 1/1", bus.err_timeout, bus.stall_id); end
    step;
    step;
    checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL tmo_keep_wait got %0b want 1", bus.stall_id); end
    drive(0, 0, 0, 0, 1, 2, 1, 32'h0);
    step;
    checks++; if (bus.stall_id !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.cnt_not_taken !== 8'd4) begin errors++; $display("FAIL tmo_resolve got %0b/%0b/%0d want 0/0/4", bus.stall_id, bus.redirect_valid, bus.cnt_not_taken); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    checks++; if (bus.err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %0b want 1", bus.err_timeout); end
    bus.clr_cnt = 1'b1;
    step;
    bus.clr_cnt = 1'b0;
    checks++; if (bus.err_timeout !== 1'b0 || bus.cnt_taken !== 8'd0 || bus.cnt_not_taken !== 8'd0) begin errors++; $display("FAIL tmo_clr got %0b/%0d/%0d want 0/0/0", bus.err_timeout, bus.cnt_taken, bus.cnt_not_taken); end
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    drive(1, 1, 0, 0, 3, 3, 1, 32'hA00);
    for (int i = 0; i < 2 * SAT; i++) begin
      step;
      if (bus.redirect_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != SAT) begin errors++; $display("FAIL b2b_pulses got %0d want %0d", pulses, SAT); end
    checks++; if (bus.cnt_taken !== 8'hFF) begin errors++; $display("FAIL sat_reach got %0h want ff", bus.cnt_taken); end
    step;
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL sat_redir got %0b want 1", bus.redirect_valid); end
    step;
    checks++; if (bus.cnt_taken !== 8'hFF) begin errors++; $display("FAIL sat_hold got %0h want ff", bus.cnt_taken); end
    step;
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL clr_setup got %0b want 1", bus.redirect_valid); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus.clr_cnt = 1'b1;
    step;
    bus.clr_cnt = 1'b0;
    checks++; if (bus.cnt_taken !== 8'h0 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL clr_vs_inc got %0h/%0b want 0/0", bus.cnt_taken, bus.redirect_valid); end
  endtask

  task automatic test_reset_mid;
    drive(1, 1, 0, 0, 1, 2, 0, 32'hC00);
    step;
    checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL rmid_wait got %0b want 1", bus.stall_id); end
    drive(0, 0, 0, 0, 5, 5, 1, 32'hC00);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.stall_id !== 1'b0 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL rmid_async got %0b/%0b want 0/0", bus.stall_id, bus.redirect_valid); end
    step;
    rst_n = 1'b1;
    step;
    checks++; if (bus.redirect_valid !== 1'b0 || bus.stall_id !== 1'b0) begin errors++; $display("FAIL rmid_after1 got %0b/%0b want 0/0", bus.redirect_valid, bus.stall_id); end
    step;
    checks++; if (bus.redirect_valid !== 1'b0 || bus.cnt_taken !== 8'd0 || bus.cnt_not_taken !== 8'd0) begin errors++; $display("FAIL rmid_after2 got %0b/%0d/%0d want 0/0/0", bus.redirect_valid, bus.cnt_taken, bus.cnt_not_taken); end
  endtask

  task automatic test_no_type;
    drive(1, 0, 0, 0, 5, 5, 1, 32'hB00);
    step;
    checks++; if (bus.redirect_valid !== 1'b0 || bus.stall_id !== 1'b0 || bus.cnt_not_taken !== 8'd0) begin errors++; $display("FAIL notype_rdy got %0b/%0b/%0d want 0/0/0", bus.redirect_valid, bus.stall_id, bus.cnt_not_taken); end
    drive(1, 0, 0, 0, 5, 6, 0, 32'hB00);
    step;
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL notype_wait got %0b want 0", bus.stall_id); end
    drive(1, 0, 1, 0, 5, 6, 1, 32'hB40);
    step;
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hB40) begin errors++; $display("FAIL notype_next got %0b/%0h want 1/b40", bus.redirect_valid, bus.redirect_pc); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    checks++; if (bus.cnt_taken !== 8'd1) begin errors++; $display("FAIL notype_cnt got %0d want 1", bus.cnt_taken); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_beq_taken;
    test_conditions;
    test_wait_ops;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_no_type;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
